// File: rtl/starfield_scroll_controller_if.sv
// Bundles the pixel-position inputs, scroll controls and renderer-facing
// outputs of the starfield scroll controller.
interface starfield_scroll_controller_if #(
  parameter int DISP_W  = 5,
  parameter int SPEED_W = 4
) ();
  logic [9:0]         x;
  logic [9:0]         y;
  logic [SPEED_W-1:0] speed;
  logic               pause;
  logic               dir;
  logic [DISP_W-1:0]  displacement;
  logic               frame_tick;
  logic               step_tick;
  logic               paused;

  // Driver side: sync generator plus control source
  modport master (
    output x, y, speed, pause, dir,
    input  displacement, frame_tick, step_tick, paused
  );

  // Controller side
  modport slave (
    input  x, y, speed, pause, dir,
    output displacement, frame_tick, step_tick, paused
  );
endinterface

// File: rtl/starfield_scroll_controller.sv
// Starfield scroll controller: detects the start of each VGA frame from the
// pixel position and advances a star displacement offset once every
// (speed+1) running frames, with pause and direction control. Every state
// change (FSM, counter, displacement) happens only at a frame-start edge.
module starfield_scroll_controller #(
  parameter int DISP_W  = 5,
  parameter int SPEED_W = 4
) (
  input logic                          clk,
  input logic                          reset,
  starfield_scroll_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SPEED_W-1:0] counter_q, counter_d;
  logic [DISP_W-1:0]  displacement_q, displacement_d;
  logic               prev_origin_q, prev_origin_d;
  logic               frame_tick_q, frame_tick_d;
  logic               step_tick_q, step_tick_d;
  logic               paused_q, paused_d;

  logic origin;
  logic frame_start;
  logic step;

  // Frame-start detection: origin may be held for several clocks when the
  // pixel enable is slower than clk, so only its rising edge counts.
  always_comb begin
    origin        = (bus.x == '0) && (bus.y == '0);
    frame_start   = origin && !prev_origin_q;
    prev_origin_d = origin;
  end

  // Next-state, frame counter and displacement update; evaluated only at
  // frame starts so mid-frame control changes are ignored until then.
  always_comb begin
    state_d        = state_q;
    counter_d      = counter_q;
    displacement_d = displacement_q;
    step           = 1'b0;

    if (frame_start) begin
      case (state_q)
        IDLE: begin
          // First frame only synchronises; no step.
          state_d   = RUN;
          counter_d = '0;
        end
        RUN, PAUSED: begin
          if (bus.pause) begin
            state_d = PAUSED;
          end else begin
            // Leaving PAUSED evaluates this frame like a normal RUN frame.
            // The >= test also catches speed lowered below the counter.
            state_d = RUN;
            if (counter_q >= bus.speed) begin
              step      = 1'b1;
              counter_d = '0;
            end else begin
              counter_d = counter_q + SPEED_W'(1);
            end
          end
        end
        default: begin
          state_d   = IDLE;
          counter_d = '0;
        end
      endcase
    end

    if (step) begin
      displacement_d = bus.dir ? (displacement_q - DISP_W'(1))
                               : (displacement_q + DISP_W'(1));
    end

    frame_tick_d = frame_start;
    step_tick_d  = step;
    paused_d     = (state_d == PAUSED);
  end

  // State register; prev_origin resets high so an origin present around
  // reset is not mistaken for a frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      counter_q      <= '0;
      displacement_q <= '0;
      prev_origin_q  <= 1'b1;
      frame_tick_q   <= 1'b0;
      step_tick_q    <= 1'b0;
      paused_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      counter_q      <= counter_d;
      displacement_q <= displacement_d;
      prev_origin_q  <= prev_origin_d;
      frame_tick_q   <= frame_tick_d;
      step_tick_q    <= step_tick_d;
      paused_q       <= paused_d;
    end
  end

  assign bus.displacement = displacement_q;
  assign bus.frame_tick   = frame_tick_q;
  assign bus.step_tick    = step_tick_q;
  assign bus.paused       = paused_q;

endmodule

// File: tb/tb_starfield_scroll_controller.sv
// Directed bench for starfield_scroll_controller: each task drives one
// scenario through emulated frames and checks hand-derived values.
module tb_starfield_scroll_controller;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  starfield_scroll_controller_if #(.DISP_W(5), .SPEED_W(4)) bus_if ();

  starfield_scroll_controller #(.DISP_W(5), .SPEED_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "timeout");
  end

  // Reset with the pixel position away from the origin.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus_if.x = 10'd5;
    bus_if.y = 10'd3;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // One frame: origin held for 2 clocks, then 3 clocks of active area.
  // Counts frame_tick/step_tick pulses seen during the frame.
  task automatic run_frame(output int ft, output int st);
    ft = 0;
    st = 0;
    @(negedge clk);
    bus_if.x = 10'd0;
    bus_if.y = 10'd0;
    repeat (2) begin
      @(negedge clk);
      ft += int'(bus_if.frame_tick);
      st += int'(bus_if.step_tick);
    end
    bus_if.x = 10'd5;
    bus_if.y = 10'd3;
    repeat (3) begin
      @(negedge clk);
      ft += int'(bus_if.frame_tick);
      st += int'(bus_if.step_tick);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_if.x = 10'd5;
    bus_if.y = 10'd3;
    bus_if.speed = 4'd0;
    bus_if.pause = 1'b0;
    bus_if.dir = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (bus_if.displacement !== 5'd0) $display("FAIL reset_disp got %0d exp 0", bus_if.displacement);
    else pass_cnt++;
    total_cnt++;
    if (bus_if.frame_tick !== 1'b0) $display("FAIL reset_frame_tick got %b exp 0", bus_if.frame_tick);
    else pass_cnt++;
    total_cnt++;
    if (bus_if.step_tick !== 1'b0) $display("FAIL reset_step_tick got %b exp 0", bus_if.step_tick);
    else pass_cnt++;
    total_cnt++;
    if (bus_if.paused !== 1'b0) $display("FAIL reset_paused got %b exp 0", bus_if.paused);
    else pass_cnt++;
  endtask

  // speed=0: first frame syncs, then one step per frame. Value entering
  // frames 1..4 is 0,0,1,2; value after frames 1..4 is 0,1,2,3.
  task automatic test_basic_speed0();
    int ft, st;
    logic [4:0] pre_exp [4];
    logic [4:0] post_exp [4];
    pre_exp  = '{5'd0, 5'd0, 5'd1, 5'd2};
    post_exp = '{5'd0, 5'd1, 5'd2, 5'd3};
    do_reset();
    bus_if.speed = 4'd0;
    bus_if.dir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (bus_if.displacement !== pre_exp[i]) $display("FAIL basic_pre_disp%0d got %0d exp %0d", i + 1, bus_if.displacement, pre_exp[i]);
      else pass_cnt++;
      run_frame(ft, st);
      total_cnt++;
      if (ft !== 1) $display("FAIL basic_frame_tick%0d got %0d pulses exp 1", i + 1, ft);
      else pass_cnt++;
      total_cnt++;
      if (bus_if.displacement !== post_exp[i]) $display("FAIL basic_post_disp%0d got %0d exp %0d", i + 1, bus_if.displacement, post_exp[i]);
      else pass_cnt++;
    end
  endtask

  // speed=3: steps on frames 4 and 8 after sync.
  task automatic test_speed3();
    int ft, st, exp_st;
    do_reset();
    bus_if.speed = 4'd3;
    bus_if.dir = 1'b0;
    run_frame(ft, st);
    for (int i = 1; i <= 9; i++) begin
      run_frame(ft, st);
      exp_st = (i == 4 || i == 8) ? 1 : 0;
      total_cnt++;
      if (st !== exp_st) $display("FAIL speed3_step%0d got %0d exp %0d", i, st, exp_st);
      else pass_cnt++;
    end
    total_cnt++;
    if (bus_if.displacement !== 5'd2) $display("FAIL speed3_disp got %0d exp 2", bus_if.displacement);
    else pass_cnt++;
  endtask

  // Wrap in both directions: 0 -> 31, 31 -> 0, 0 -> 31.
  task automatic test_wrap();
    int ft, st;
    do_reset();
    bus_if.speed = 4'd0;
    bus_if.dir = 1'b1;
    run_frame(ft, st);
    run_frame(ft, st);
    total_cnt++;
    if (bus_if.displacement !== 5'd31) $display("FAIL wrap_down_first got %0d exp 31", bus_if.displacement);
    else pass_cnt++;
    bus_if.dir = 1'b0;
    run_frame(ft, st);
    total_cnt++;
    if (bus_if.displacement !== 5'd0) $display("FAIL wrap_up got %0d exp 0", bus_if.displacement);
    else pass_cnt++;
    bus_if.dir = 1'b1;
    run_frame(ft, st);
    total_cnt++;
    if (bus_if.displacement !== 5'd31) $display("FAIL wrap_down got %0d exp 31", bus_if.displacement);
    else pass_cnt++;
  endtask

  task automatic test_pause();
    int ft, st;
    do_reset();
    bus_if.speed = 4'd0;
    bus_if.dir = 1'b0;
    run_frame(ft, st);
    run_frame(ft, st);
    run_frame(ft, st);
    // Mid-frame pause request: nothing changes until the next frame start.
    @(negedge clk);
    bus_if.pause = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (bus_if.paused !== 1'b0) $display("FAIL pause_midframe_paused got %b exp 0", bus_if.paused);
    else pass_cnt++;
    total_cnt++;
    if (bus_if.displacement !== 5'd2) $display("FAIL pause_midframe_disp got %0d exp 2", bus_if.displacement);
    else pass_cnt++;
    for (int i = 1; i <= 3; i++) begin
      run_frame(ft, st);
      total_cnt++;
      if (ft !== 1) $display("FAIL pause_frame_tick%0d got %0d pulses exp 1", i, ft);
      else pass_cnt++;
      total_cnt++;
      if (st !== 0) $display("FAIL pause_step%0d got %0d exp 0", i, st);
      else pass_cnt++;
      total_cnt++;
      if (bus_if.paused !== 1'b1) $display("FAIL pause_paused%0d got %b exp 1", i, bus_if.paused);
      else pass_cnt++;
      total_cnt++;
      if (bus_if.displacement !== 5'd2) $display("FAIL pause_disp%0d got %0d exp 2", i, bus_if.displacement);
      else pass_cnt++;
    end
    bus_if.pause = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (bus_if.paused !== 1'b1) $display("FAIL resume_midframe_paused got %b exp 1", bus_if.paused);
    else pass_cnt++;
    run_frame(ft, st);
    total_cnt++;
    if (st !== 1) $display("FAIL resume_step got %0d exp 1", st);
    else pass_cnt++;
    total_cnt++;
    if (bus_if.displacement !== 5'd3) $display("FAIL resume_disp got %0d exp 3", bus_if.displacement);
    else pass_cnt++;
    total_cnt++;
    if (bus_if.paused !== 1'b0) $display("FAIL resume_paused got %b exp 0", bus_if.paused);
    else pass_cnt++;
  endtask

  // Reset during pause with origin held through and after release.
  task automatic test_reset_origin();
    int ft, st;
    do_reset();
    bus_if.speed = 4'd0;
    bus_if.dir = 1'b0;
    run_frame(ft, st);
    run_frame(ft, st);
    bus_if.pause = 1'b1;
    run_frame(ft, st);
    @(negedge clk);
    bus_if.x = 10'd0;
    bus_if.y = 10'd0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus_if.pause = 1'b0;
    ft = 0;
    repeat (3) begin
      @(negedge clk);
      ft += int'(bus_if.frame_tick);
    end
    total_cnt++;
    if (ft !== 0) $display("FAIL rstorg_held_ticks got %0d exp 0", ft);
    else pass_cnt++;
    total_cnt++;
    if (bus_if.paused !== 1'b0) $display("FAIL rstorg_paused got %b exp 0", bus_if.paused);
    else pass_cnt++;
    total_cnt++;
    if (bus_if.displacement !== 5'd0) $display("FAIL rstorg_disp got %0d exp 0", bus_if.displacement);
    else pass_cnt++;
    bus_if.x = 10'd7;
    repeat (2) begin
      @(negedge clk);
      ft += int'(bus_if.frame_tick);
    end
    total_cnt++;
    if (ft !== 0) $display("FAIL rstorg_drop_ticks got %0d exp 0", ft);
    else pass_cnt++;
    run_frame(ft, st);
    total_cnt++;
    if (ft !== 1 || st !== 0) $display("FAIL rstorg_sync got ft=%0d st=%0d exp ft=1 st=0", ft, st);
    else pass_cnt++;
    total_cnt++;
    if (bus_if.displacement !== 5'd0) $display("FAIL rstorg_sync_disp got %0d exp 0", bus_if.displacement);
    else pass_cnt++;
    run_frame(ft, st);
    total_cnt++;
    if (bus_if.displacement !== 5'd1) $display("FAIL rstorg_run_disp got %0d exp 1", bus_if.displacement);
    else pass_cnt++;
  endtask

  // speed=7 with counter at 5, then speed lowered to 2 mid-frame.
  task automatic test_speed_lower();
    int ft, st, st_sum;
    do_reset();
    bus_if.speed = 4'd7;
    bus_if.dir = 1'b0;
    run_frame(ft, st);
    st_sum = 0;
    for (int i = 0; i < 5; i++) begin
      run_frame(ft, st);
      st_sum += st;
    end
    total_cnt++;
    if (st_sum !== 0) $display("FAIL lower_presteps got %0d exp 0", st_sum);
    else pass_cnt++;
    @(negedge clk);
    bus_if.speed = 4'd2;
    bus_if.dir = 1'b1;
    bus_if.dir = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (bus_if.displacement !== 5'd0) $display("FAIL lower_midframe_disp got %0d exp 0", bus_if.displacement);
    else pass_cnt++;
    run_frame(ft, st);
    total_cnt++;
    if (st !== 1) $display("FAIL lower_step got %0d exp 1", st);
    else pass_cnt++;
    total_cnt++;
    if (bus_if.displacement !== 5'd1) $display("FAIL lower_disp got %0d exp 1", bus_if.displacement);
    else pass_cnt++;
    // Counter restarted at 0: next step lands on the third frame.
    for (int i = 1; i <= 3; i++) begin
      run_frame(ft, st);
      total_cnt++;
      if (st !== ((i == 3) ? 1 : 0)) $display("FAIL lower_after%0d got %0d exp %0d", i, st, (i == 3) ? 1 : 0);
      else pass_cnt++;
    end
    total_cnt++;
    if (bus_if.displacement !== 5'd2) $display("FAIL lower_final_disp got %0d exp 2", bus_if.displacement);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    reset = 1'b1;
    bus_if.x = 10'd5;
    bus_if.y = 10'd3;
    bus_if.speed = 4'd0;
    bus_if.pause = 1'b0;
    bus_if.dir = 1'b0;
    test_reset();
    test_basic_speed0();
    test_speed3();
    test_wrap();
    test_pause();
    test_reset_origin();
    test_speed_lower();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
